// File: rtl/clk_factor_arbiter_if.sv
// rtl/clk_factor_arbiter_if.sv - request and status bundle for the clock-factor arbiter
interface clk_factor_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_factor;
  logic [NREQ-1:0]   req_grant;
  logic [NREQ-1:0]   req_nack;
  logic              busy;
  logic [4:0]        cur_factor;
  logic [OW-1:0]     cur_owner;
  logic              clk_div_out;
  logic              clk_tick;

  modport master (
    output req_valid, req_factor,
    input  req_grant, req_nack, busy, cur_factor, cur_owner, clk_div_out, clk_tick
  );

  modport slave (
    input  req_valid, req_factor,
    output req_grant, req_nack, busy, cur_factor, cur_owner, clk_div_out, clk_tick
  );
endinterface

// File: rtl/clk_factor_arbiter.sv
// rtl/clk_factor_arbiter.sv - shared clock divider with round-robin, glitch-free factor switching
module clk_factor_arbiter #(
  parameter int         NREQ           = 4,
  parameter int         SIZE           = 32,
  parameter logic [4:0] DEFAULT_FACTOR = 5'd1
) (
  input  logic                 clk_gen_fsys,
  input  logic                 clk_gen_rst,
  clk_factor_arbiter_if.slave  bus
);
  localparam int OW   = $clog2(NREQ);
  localparam int MAXF = (SIZE < 31) ? SIZE : 31;

  typedef enum logic [1:0] {IDLE, ARB, WAIT_SAFE, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [4:0]      cur_factor_q, cur_factor_d;
  logic [4:0]      new_factor_q, new_factor_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   win_q, win_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] nack_q, nack_d;

  logic [SIZE-1:0] low_mask, sel_bit;
  logic [OW-1:0]   win_next, ptr_after;
  logic [4:0]      sel_factor;
  logic            found, tick, div_out, factor_ok, pulse_now;

  // Masks derived from the factor avoid any out-of-range variable bit select.
  always_comb begin
    low_mask = '0;
    sel_bit  = '0;
    for (int i = 0; i < SIZE; i++) begin
      low_mask[i] = (i < int'(cur_factor_q));
      sel_bit[i]  = (i == int'(cur_factor_q) - 1);
    end
  end

  assign tick    = &(cnt_q | ~low_mask);
  assign div_out = |(cnt_q & sel_bit);

  always_comb begin
    win_next = rr_ptr_q;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        win_next = OW'((int'(rr_ptr_q) + k) % NREQ);
        found    = 1'b1;
      end
    end
  end

  assign sel_factor = bus.req_factor[5*win_next +: 5];
  assign ptr_after  = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
  assign factor_ok  = (new_factor_q != 5'd0) && (int'(new_factor_q) <= MAXF);
  assign pulse_now  = (|grant_q) || (|nack_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    cur_factor_d = cur_factor_q;
    new_factor_d = new_factor_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    owner_d      = owner_q;
    grant_d      = '0;
    nack_d       = '0;
    unique case (state_q)
      IDLE: begin
        // A client still holds req_valid during its own grant/nack cycle.
        if (found && !pulse_now) begin
          win_d        = win_next;
          new_factor_d = sel_factor;
          state_d      = ARB;
        end
      end
      ARB: begin
        if (!factor_ok) begin
          nack_d[win_q] = 1'b1;
          rr_ptr_d      = ptr_after;
          state_d       = IDLE;
        end else if (new_factor_q == cur_factor_q) begin
          grant_d[win_q] = 1'b1;
          owner_d        = win_q;
          rr_ptr_d       = ptr_after;
          state_d        = IDLE;
        end else begin
          state_d = WAIT_SAFE;
        end
      end
      WAIT_SAFE: begin
        if (tick) begin
          cnt_d          = '0;
          cur_factor_d   = new_factor_q;
          grant_d[win_q] = 1'b1;
          owner_d        = win_q;
          rr_ptr_d       = ptr_after;
          state_d        = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gen_fsys or posedge clk_gen_rst) begin
    if (clk_gen_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_factor_q <= DEFAULT_FACTOR;
      new_factor_q <= DEFAULT_FACTOR;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      nack_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_factor_q <= cur_factor_d;
      new_factor_q <= new_factor_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      nack_q       <= nack_d;
    end
  end

  assign bus.req_grant   = grant_q;
  assign bus.req_nack    = nack_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cur_factor  = cur_factor_q;
  assign bus.cur_owner   = owner_q;
  assign bus.clk_div_out = div_out;
  assign bus.clk_tick    = tick;
endmodule

// File: tb/tb_clk_factor_arbiter.sv
// tb/tb_clk_factor_arbiter.sv - randomized clients against a schedule-based reference model
module tb_clk_factor_arbiter;
  localparam int NREQ = 4;
  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_factor_arbiter_if #(.NREQ(NREQ)) bus ();

  clk_factor_arbiter #(
    .NREQ(NREQ),
    .SIZE(SIZE),
    .DEFAULT_FACTOR(5'd1)
  ) dut (
    .clk_gen_fsys(clk),
    .clk_gen_rst (rst),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Model: counter arithmetic plus a schedule of when the next pulse / switch lands.
  logic [31:0] m_cnt;
  int          m_fac, m_owner, m_rr;
  longint      cyc, free_at, ev_cyc, sw_cyc;
  int          ev_kind, ev_w, sw_f;
  bit          c_drop[NREQ];

  task automatic model_reset();
    m_cnt   = '0;
    m_fac   = 1;
    m_owner = 0;
    m_rr    = 0;
    free_at = cyc;
    ev_cyc  = -1;
    sw_cyc  = -1;
    for (int i = 0; i < NREQ; i++) c_drop[i] = 1'b0;
  endtask

  task automatic step(input bit allow_new);
    logic [NREQ-1:0] eg, en, just;
    logic [31:0]     mask;
    int              w, f, r;
    longint          p, k;
    eg = '0;
    en = '0;
    just = '0;
    if (cyc == ev_cyc) begin
      if (ev_kind == 1) begin
        eg[ev_w] = 1'b1;
        m_owner  = ev_w;
      end else begin
        en[ev_w] = 1'b1;
      end
      m_rr = (ev_w + 1) % NREQ;
    end
    mask = (32'd1 << m_fac) - 32'd1;
    check("busy", bus.busy, longint'(cyc < free_at));
    check("grant", bus.req_grant, eg);
    check("nack", bus.req_nack, en);
    check("cur_factor", bus.cur_factor, m_fac);
    check("cur_owner", bus.cur_owner, m_owner);
    check("clk_div_out", bus.clk_div_out, m_cnt[m_fac-1]);
    check("clk_tick", bus.clk_tick, longint'((m_cnt & mask) == mask));

    for (int i = 0; i < NREQ; i++) begin
      if (c_drop[i]) begin
        bus.req_valid[i] = 1'b0;
        c_drop[i] = 1'b0;
        just[i] = 1'b1;
      end
      if (eg[i] || en[i]) c_drop[i] = 1'b1;
    end
    if (allow_new) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && !just[i] && $urandom_range(7) == 0) begin
          r = $urandom_range(5);
          f = (r == 0) ? 0 : (r == 1) ? m_fac : $urandom_range(5, 1);
          bus.req_factor[5*i +: 5] = 5'(f);
          bus.req_valid[i] = 1'b1;
        end
      end
    end

    if (cyc >= free_at && eg == '0 && en == '0 && bus.req_valid != '0) begin
      w = m_rr;
      while (!bus.req_valid[w]) w = (w + 1) % NREQ;
      f    = int'(bus.req_factor[5*w +: 5]);
      ev_w = w;
      if (f == 0 || f > 31) begin
        ev_kind = 2;
        ev_cyc  = cyc + 2;
        free_at = cyc + 2;
      end else if (f == m_fac) begin
        ev_kind = 1;
        ev_cyc  = cyc + 2;
        free_at = cyc + 2;
      end else begin
        p       = longint'(1) << m_fac;
        k       = longint'(m_cnt + 32'd2) % p;
        sw_cyc  = cyc + 2 + (p - 1 - k);
        sw_f    = f;
        ev_kind = 1;
        ev_cyc  = sw_cyc + 1;
        free_at = sw_cyc + 2;
      end
    end

    if (cyc == sw_cyc) begin
      m_cnt = '0;
      m_fac = sw_f;
    end else begin
      m_cnt = m_cnt + 32'd1;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_grant"}, bus.req_grant, 0);
    check({tag, "_nack"}, bus.req_nack, 0);
    check({tag, "_factor"}, bus.cur_factor, 1);
    check({tag, "_owner"}, bus.cur_owner, 0);
    check({tag, "_div"}, bus.clk_div_out, 0);
    check({tag, "_tick"}, bus.clk_tick, 0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      step(1'b0);
      ok = (cyc >= free_at) && (bus.req_valid == '0) && (c_drop[0] | c_drop[1] | c_drop[2] | c_drop[3]) == 1'b0;
    end
    check("drain_idle", ok, 1);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_factor = '0;
    cyc = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    model_reset();
    step(1'b1);
    repeat (3000) begin
      @(negedge clk);
      step(1'b1);
    end

    drain();
    bus.req_factor[4:0] = (m_fac == 6) ? 5'd7 : 5'd6;
    bus.req_valid[0]    = 1'b1;
    step(1'b0);
    @(negedge clk);
    step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0);
    repeat (150) begin
      @(negedge clk);
      step(1'b0);
    end
    repeat (500) begin
      @(negedge clk);
      step(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
